// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU I/O UART transmitter.
// The optional PARITY state exists only when UART_TX_PARITY_EN is defined.
package cpu_io_pkg;

  // Level of the serial line between frames and during the stop bit.
  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit FIFO: synchronous write and pop, head byte visible combinationally,
// pointers wrap modulo DEPTH (a power of two). Writes while full are dropped.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Occupancy: a write and a pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the queue and ignores writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Byte storage (no reset needed; only entries below count are ever read).
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_con.sv
// UART transmitter with FIFO: 8N1 frames (8E1 when UART_TX_PARITY_EN is
// defined), LSB first, each bit held CLK_HZ/BAUD cycles. Back-to-back frames
// follow the stop bit with no idle gap while the FIFO holds data.
module uart_tx_con
  import cpu_io_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        tx
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  uart_state_e      state_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [7:0]       data_q;
  logic             tx_q;

  logic             div_last;
  logic             pop;
  logic             fifo_empty;
  logic [7:0]       head;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (fifo_count),
    .full_o    (full),
    .empty_o   (fifo_empty)
  );

  assign div_last = (div_q == DIV_LAST);
  // Pop from IDLE immediately, or at the last stop-bit cycle to chain frames.
  assign pop  = !fifo_empty &&
                ((state_q == ST_IDLE) || ((state_q == ST_STOP) && div_last));
  assign busy = (state_q != ST_IDLE) || !fifo_empty;
  assign tx   = tx_q;

  // Frame sequencer: state, bit divider, bit index and registered line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q  <= UART_IDLE_LVL;
          div_q <= '0;
          if (pop) begin
            data_q  <= head;
            state_q <= ST_START;
            tx_q    <= ~UART_IDLE_LVL;
          end
        end
        ST_START: begin
          if (div_last) begin
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= data_q[0];
            state_q <= ST_DATA;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (div_last) begin
            div_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= even_parity(data_q);
`else
              state_q <= ST_STOP;
              tx_q    <= UART_IDLE_LVL;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= data_q[bit_q + 3'd1];
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (div_last) begin
            div_q   <= '0;
            state_q <= ST_STOP;
            tx_q    <= UART_IDLE_LVL;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (div_last) begin
            div_q <= '0;
            if (pop) begin
              data_q  <= head;
              state_q <= ST_START;
              tx_q    <= ~UART_IDLE_LVL;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= UART_IDLE_LVL;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          div_q   <= '0;
          tx_q    <= UART_IDLE_LVL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_con.sv
// Bench for uart_tx_con: instance A (DIV=10) checked through a scoreboard of
// expected bytes and frame start cycles; instance B (DIV=199) bit timing.
module tb_uart_tx_con;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int DIV   = 10;
  localparam int FRAME = NB * DIV;
  localparam int DIV_B = 199;

  typedef struct {
    logic [7:0] d;
    int         st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, busy, tx;
  logic [3:0] fifo_count;
  logic       wr_en_b = 1'b0;
  logic [7:0] wr_data_b = 8'h00;
  logic       full_b, busy_b, tx_b;
  logic [3:0] fifo_count_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_con #(.CLK_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .fifo_count(fifo_count), .busy(busy), .tx(tx)
  );

  uart_tx_con #(.CLK_HZ(23000000), .BAUD(115200), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b),
    .fifo_count(fifo_count_b), .busy(busy_b), .tx(tx_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, output int n);
    exp_t e;
    wr_en   = 1'b1;
    wr_data = d;
    step();
    n       = cyc;
    wr_en   = 1'b0;
    e.d     = d;
    e.st    = n + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int limit, input int exp_cyc, input string name);
    int k = 0;
    while (busy && k < limit) begin
      step();
      k++;
    end
    chk(name, cyc, exp_cyc);
  endtask

  // Monitor: decode every frame on tx, then compare with the scoreboard head.
  initial begin
    int         st, glitch;
    logic       ab;
    logic [NB-1:0] lvl;
    logic [7:0] rxb;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst || tx !== 1'b0) continue;
      st = cyc; ab = 1'b0; glitch = 0; lvl = '0;
      for (int w = 0; w < NB && !ab; w++) begin
        for (int c = 0; c < DIV && !ab; c++) begin
          if (w != 0 || c != 0) @(negedge clk);
          if (rst) ab = 1'b1;
          else if (c == 0) lvl[w] = tx;
          else if (tx !== lvl[w]) glitch++;
        end
      end
      if (ab) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        continue;
      end
      for (int i = 0; i < 8; i++) rxb[i] = lvl[i+1];
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", int'(rxb), -1);
      end else begin
        e = exp_q.pop_front();
        chk("frame_start_cycle", st, e.st);
        chk("frame_data", int'(rxb), int'(e.d));
        chk("frame_stop_bit", int'(lvl[NB-1]), 1);
        chk("frame_bit_width", glitch, 0);
`ifdef UART_TX_PARITY_EN
        chk("frame_parity", int'(lvl[9]), int'(^e.d));
`endif
      end
    end
  end

  // Stimulus
  initial begin
    int n, first, run, t;
    logic run_done;

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_full", full, 0);
    chk("reset_count", fifo_count, 0);
    chk("reset_tx_b", tx_b, 1);

    // Single byte 0x55: start one cycle after the write, busy falls after frame.
    send(8'h55, n);
    chk("count_after_write", fifo_count, 1);
    chk("busy_after_write", busy, 1);
    wait_idle(FRAME + 50, n + 1 + FRAME, "busy_fall_55");

    // Ten back-to-back writes; the tenth meets a full FIFO and is dropped.
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      wr_en   = 1'b1;
      wr_data = 8'(k);
      step();
      if (k == 0) n = cyc;
      if (k < 9) begin
        e.d  = 8'(k);
        e.st = n + 1 + k * FRAME;
        exp_q.push_back(e);
      end
      chk("burst_count", fifo_count, (k == 0) ? 1 : ((k > 8) ? 8 : k));
      chk("burst_full", full, (k >= 8) ? 1 : 0);
    end
    wr_en = 1'b0;
    wait_idle(10 * FRAME, n + 1 + 9 * FRAME, "busy_fall_burst");

    // Reset during data bit 3 of 0xA3, with a write attempted in the reset cycle.
    send(8'hA3, n);
    while (cyc < n + 44) step();
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    step();
    rst   = 1'b0;
    wr_en = 1'b0;
    chk("abort_tx", tx, 1);
    chk("abort_count", fifo_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_full", full, 0);
    repeat (5) step();
    chk("abort_tx_hold", tx, 1);
    chk("abort_busy_hold", busy, 0);

    send(8'h3C, n);
    wait_idle(FRAME + 50, n + 1 + FRAME, "busy_fall_3C");
    send(8'h07, n);
    wait_idle(FRAME + 50, n + 1 + FRAME, "busy_fall_07");
    send(8'h55, n);
    wait_idle(FRAME + 50, n + 1 + FRAME, "busy_fall_55b");

    // Instance B: 0xFF at DIV=199, start bit width and whole-frame duration.
    wr_en_b   = 1'b1;
    wr_data_b = 8'hFF;
    step();
    n       = cyc;
    wr_en_b = 1'b0;
    first = -1; run = 0; run_done = 1'b0; t = 0;
    while (busy_b && t < 4000) begin
      step();
      t++;
      if (tx_b == 1'b0) begin
        if (first < 0) first = cyc;
        if (!run_done) run++;
      end else if (first >= 0) begin
        run_done = 1'b1;
      end
    end
    chk("b_start_cycle", first, n + 1);
    chk("b_start_width", run, DIV_B);
    chk("b_busy_fall", cyc, n + 1 + NB * DIV_B);

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
